// File: rtl/pc_update_unit.sv
// Fetch PC sequencer: BOOT/RUN state, redirect capture with a one-entry pending target.
// Define PC_MISALIGN_CHECK_EN to enable the sticky misaligned-target flag.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  pc_select_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jump_target_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        redirect_pending_o,
  output logic        misalign_err_o
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic        live;
    logic [31:0] raw;
    logic [31:0] tgt;
  } redirect_t;

  state_t      state, state_next;
  redirect_t   redir;
  logic        fire;
  logic [31:0] pend_tgt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    fetch_valid_o = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN:  fetch_valid_o = 1'b1;
      default: state_next = BOOT;
    endcase
  end

  // Select 0 and 3 are both sequential; only 1 and 2 carry a target.
  always_comb begin
    redir.live = redirect_valid_i && (pc_select_i == 2'd1 || pc_select_i == 2'd2);
    redir.raw  = (pc_select_i == 2'd2) ? jump_target_i : branch_target_i;
    redir.tgt  = redir.raw & 32'hFFFF_FFFC;
  end

  assign fire       = fetch_valid_o & fetch_ready_i;
  assign pc_plus4_o = pc_o + 32'd4;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_o               <= RESET_PC;
      redirect_pending_o <= 1'b0;
      pend_tgt           <= 32'h0;
    end else if (fire) begin
      if (redir.live)              pc_o <= redir.tgt;
      else if (redirect_pending_o) pc_o <= pend_tgt;
      else                         pc_o <= pc_plus4_o;
      redirect_pending_o <= 1'b0;
    end else if (redir.live) begin
      // Latest redirect wins while fetch is stalled or still booting.
      pend_tgt           <= redir.tgt;
      redirect_pending_o <= 1'b1;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                   misalign_err_o <= 1'b0;
    else if (redir.live && redir.raw[1:0] != 2'b00) misalign_err_o <= 1'b1;
  end
`else
  assign misalign_err_o = 1'b0;
`endif

endmodule

// File: doc/pc_update_unit.md
PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pc_select_i  input  2  0 = sequential, 1 = branch target, 2 = jump target, 3 = reserved (treated as 0).
REQ-005 SHALL have port redirect_valid_i  input  1  qualifies pc_select_i and the targets for this cycle.
REQ-006 SHALL have port branch_target_i  input  32  branch destination.
REQ-007 SHALL have port jump_target_i  input  32  jump or jr destination.
REQ-008 SHALL have port fetch_ready_i  input  1  instruction memory accepts pc_o this cycle.
REQ-009 SHALL have port fetch_valid_o  output  1  pc_o is a valid fetch request.
REQ-010 SHALL have port pc_o  output  32  current fetch PC.
REQ-011 SHALL have port pc_plus4_o  output  32  pc_o + 4, combinational.
REQ-012 SHALL have port redirect_pending_o  output  1  a captured redirect awaits the next handshake.
REQ-013 SHALL have port misalign_err_o  output  1  sticky misaligned-target flag.

Function
REQ-014 SHALL implement FSM states BOOT and RUN; reset enters BOOT; BOOT->RUN on the first clock edge after reset release; RUN is held until reset.
REQ-015 SHALL drive fetch_valid_o = 0 in BOOT and 1 in RUN.
REQ-016 SHALL define fire = fetch_valid_o AND fetch_ready_i.
REQ-017 SHALL define a live redirect as redirect_valid_i = 1 with pc_select_i equal to 1 or 2; its target is branch_target_i for 1 and jump_target_i for 2.
REQ-018 SHALL, on fire, load pc_o from the first true case, in priority order: live redirect target; pending target; pc_o + 4.
REQ-019 SHALL clear the pending flag on fire.
REQ-020 SHALL, on a live redirect without fire (including BOOT), capture the target into the pending register and set redirect_pending_o; a later redirect overwrites the earlier one.
REQ-021 SHALL hold pc_o stable while fetch_valid_o = 1 and fetch_ready_i = 0.
REQ-022 SHALL ignore pc_select_i = 0 or 3, and any value while redirect_valid_i = 0, with no state change.
REQ-023 SHALL compute pc + 4 modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-024 SHALL handle the first fire after BOOT using REQ-018 (pending redirect honoured).
REQ-025 SHALL introduce zero-cycle latency for a redirect on a fire cycle: the target appears on pc_o the next cycle.

Reset
REQ-026 SHALL, while rst_i = 0 and independent of clk_i, set pc_o = RESET_PC, fetch_valid_o = 0, redirect_pending_o = 0, pending target = 0, misalign_err_o = 0 and state = BOOT.
REQ-027 SHALL discard any in-flight redirect or pending target when reset asserts mid-operation.

Configuration
REQ-028 SHALL provide macro PC_MISALIGN_CHECK_EN.
REQ-029 SHALL, when PC_MISALIGN_CHECK_EN is defined, set misalign_err_o (sticky until reset) on any live redirect whose target bits [1:0] are not zero.
REQ-030 SHALL, in all builds, clear target bits [1:0] before loading into pc_o or the pending register.
REQ-031 SHALL, when PC_MISALIGN_CHECK_EN is undefined, tie misalign_err_o to 0 with no flag logic.

Verification
REQ-032 SHALL cover reset release with fetch_ready_i = 1 and no redirect -> pc_o sequence 0, 0, 4, 8; fetch_valid_o goes 0 then 1 after one edge.
REQ-033 SHALL cover a branch (select 1, target 0x40) on a fire cycle at pc_o = 0x8 -> next pc_o = 0x40 and redirect_pending_o stays 0.
REQ-034 SHALL cover fetch_ready_i = 0 for 3 cycles with a jump (select 2, target 0x100) in cycle 1 -> pc_o held and redirect_pending_o = 1; after ready returns, pc_o = 0x100 and pending clears.
REQ-035 SHALL cover a pending target 0x100 plus a live branch to 0x200 on the fire cycle -> pc_o = 0x200 and pending clears.
REQ-036 SHALL cover pc_o = 0xFFFF_FFFC with a sequential fire -> pc_o = 0x0.
REQ-037 SHALL cover PC_MISALIGN_CHECK_EN defined with a jump to 0x102 -> pc_o = 0x100 and misalign_err_o = 1 until rst_i = 0; with the macro undefined, the same stimulus gives misalign_err_o = 0.
